// File: rtl/countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_timer : MM:SS BCD countdown with load/start/pause and done flag |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module countdown_timer #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [2:0] set_min_tens,
  input  logic [3:0] set_min_ones,
  input  logic [2:0] set_sec_tens,
  input  logic [3:0] set_sec_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [2:0]    min_tens_n, sec_tens_n;
  logic [3:0]    min_ones_n, sec_ones_n;

  logic [2:0] clamp_mt, clamp_st;
  logic [3:0] clamp_mo, clamp_so;
  logic [2:0] dec_mt, dec_st;
  logic [3:0] dec_mo, dec_so;
  logic       borrow_s, borrow_st, borrow_mo;
  logic       tick, digits_zero, dec_zero;

  // Presets out of BCD range saturate at the largest legal digit.
  always_comb begin
    clamp_mt = (set_min_tens > 3'd5) ? 3'd5 : set_min_tens;
    clamp_mo = (set_min_ones > 4'd9) ? 4'd9 : set_min_ones;
    clamp_st = (set_sec_tens > 3'd5) ? 3'd5 : set_sec_tens;
    clamp_so = (set_sec_ones > 4'd9) ? 4'd9 : set_sec_ones;
  end

  // One-second decrement with the borrow rippling up through all four digits.
  always_comb begin
    borrow_s  = (sec_ones == 4'd0);
    borrow_st = borrow_s && (sec_tens == 3'd0);
    borrow_mo = borrow_st && (min_ones == 4'd0);
    dec_so    = borrow_s ? 4'd9 : sec_ones - 4'd1;
    dec_st    = borrow_s ? ((sec_tens == 3'd0) ? 3'd5 : sec_tens - 3'd1) : sec_tens;
    dec_mo    = borrow_st ? ((min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1) : min_ones;
    dec_mt    = borrow_mo ? ((min_tens == 3'd0) ? 3'd5 : min_tens - 3'd1) : min_tens;
    dec_zero  = (dec_mt == 3'd0) && (dec_mo == 4'd0) && (dec_st == 3'd0) && (dec_so == 4'd0);
    digits_zero = (min_tens == 3'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 3'd0) && (sec_ones == 4'd0);
    tick      = (state == RUN) && (presc == PRESC_MAX);
  end

  always_comb begin
    state_n    = state;
    presc_n    = presc;
    min_tens_n = min_tens;
    min_ones_n = min_ones;
    sec_tens_n = sec_tens;
    sec_ones_n = sec_ones;
    case (state)
      IDLE, PAUSE, DONE: begin
        if (state != PAUSE) presc_n = '0;
        if (load) begin
          state_n    = IDLE;
          presc_n    = '0;
          min_tens_n = clamp_mt;
          min_ones_n = clamp_mo;
          sec_tens_n = clamp_st;
          sec_ones_n = clamp_so;
        end else if (state == IDLE && start && !digits_zero) begin
          state_n = RUN;
        end else if (state == PAUSE && start && !pause) begin
          state_n = RUN;
        end
      end
      RUN: begin
        // Pause takes priority over a coincident tick; the prescaler holds.
        if (pause) begin
          state_n = PAUSE;
        end else if (tick) begin
          presc_n    = '0;
          min_tens_n = dec_mt;
          min_ones_n = dec_mo;
          sec_tens_n = dec_st;
          sec_ones_n = dec_so;
          if (dec_zero) state_n = DONE;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      min_tens <= 3'd0;
      min_ones <= 4'd0;
      sec_tens <= 3'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      min_tens <= min_tens_n;
      min_ones <= min_ones_n;
      sec_tens <= sec_tens_n;
      sec_ones <= sec_ones_n;
      running  <= (state_n == RUN);
      done     <= (state_n == DONE);
    end
  end

endmodule
`default_nettype wire
